// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
// Write-domain control stage of the asynchronous circular FIFO. It sits
// directly upstream of fifo_memory. It owns the binary write pointer and
// brings the read domain's Gray pointer into w_clk through a synchroniser.
// From those it derives full, a fill-level estimate and a sticky overflow
// flag. The registered Gray write pointer is exported to the read domain.
//
// Optional feature macro: FIFO_ALMOST_FULL_EN
//   When defined, adds almost_full_out and the AF_THRESHOLD comparison.
//   When undefined, that port and its logic are absent.
//
// Parameters
//   DEPTH        FIFO entries, equal to 2**(PTR_WIDTH-1)
//   PTR_WIDTH    address bits plus one wrap bit
//   SYNC_STAGES  flops in the read-pointer synchroniser (at least 2)
//   AF_THRESHOLD almost-full level, 1..DEPTH-1
//
// Ports
//   w_clk              write-domain clock
//   w_rst_n            asynchronous active-low reset
//   write_in           write request (also drives fifo_memory write_in)
//   read_ptr_gray_in   Gray read pointer from the read domain (asynchronous)
//   write_ptr_out      binary write pointer to fifo_memory
//   write_ptr_gray_out registered Gray write pointer to the read domain
//   full_out           FIFO full, registered
//   level_out          write-side fill estimate, 0..DEPTH
//   overflow_out       sticky flag: a write was attempted while full
//   almost_full_out    level >= AF_THRESHOLD (FIFO_ALMOST_FULL_EN only)
// ---------------------------------------------------------------------------
module fifo_wptr_full #(
   parameter int DEPTH        = 16,
   parameter int PTR_WIDTH    = 5,
   parameter int SYNC_STAGES  = 2,
   parameter int AF_THRESHOLD = 12
) (
   input  logic                 w_clk,
   input  logic                 w_rst_n,
   input  logic                 write_in,
   input  logic [PTR_WIDTH-1:0] read_ptr_gray_in,
   output logic [PTR_WIDTH-1:0] write_ptr_out,
   output logic [PTR_WIDTH-1:0] write_ptr_gray_out,
   output logic                 full_out,
   output logic [PTR_WIDTH-1:0] level_out,
   output logic                 overflow_out
`ifdef FIFO_ALMOST_FULL_EN
   ,
   output logic                 almost_full_out
`endif
);

   // Address width derived from DEPTH; it must match PTR_WIDTH-1.
   localparam int ADDR_W = $clog2(DEPTH);

   // Reject inconsistent configurations at elaboration time.
   if (DEPTH != (1 << (PTR_WIDTH - 1)) || ADDR_W != PTR_WIDTH - 1) begin : g_bad_depth
      $fatal(1, "fifo_wptr_full: DEPTH must equal 2**(PTR_WIDTH-1)");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "fifo_wptr_full: SYNC_STAGES must be at least 2");
   end
   if (AF_THRESHOLD < 1 || AF_THRESHOLD >= DEPTH) begin : g_bad_af
      $fatal(1, "fifo_wptr_full: AF_THRESHOLD must be in 1..DEPTH-1");
   end

   logic [PTR_WIDTH-1:0] wbin;
   logic [PTR_WIDTH-1:0] wgray;
   logic [PTR_WIDTH-1:0] wbin_next;
   logic [PTR_WIDTH-1:0] wgray_next;
   logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [PTR_WIDTH-1:0] rq;
   logic [PTR_WIDTH-1:0] rbin_s;
   logic [PTR_WIDTH-1:0] full_match;
   logic [PTR_WIDTH-1:0] level_next;
   logic                 accept;
   logic                 full_next;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
      logic [PTR_WIDTH-1:0] b;
      b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
      for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Next pointer values. A write is accepted only when the registered full
   // flag is low, so a refused write leaves both pointers unchanged. The binary
   // pointer wraps naturally at 2**PTR_WIDTH.
   always_comb begin
      accept     = write_in & ~full_out;
      wbin_next  = wbin + {{(PTR_WIDTH-1){1'b0}}, accept};
      wgray_next = wbin_next ^ (wbin_next >> 1);
   end

   // Full and level are computed from the synchronised read pointer. In Gray
   // code, "full" means the two MSBs are inverted and the rest match. The
   // fill estimate is a modular binary difference; it may read high while the
   // synchroniser lags, which is the safe direction.
   always_comb begin
      rq         = sync_q[SYNC_STAGES-1];
      rbin_s     = gray2bin(rq);
      full_match = {~rq[PTR_WIDTH-1:PTR_WIDTH-2], rq[ADDR_W-2:0]};
      full_next  = (wgray_next == full_match);
      level_next = wbin_next - rbin_s;
   end

   // Read-pointer synchroniser. Only the Gray form crosses the clock domain,
   // so at most one bit changes per read-side update.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= read_ptr_gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Pointer, flag and level registers. The write that fills the last entry
   // raises full on the same edge that advances the pointer, because full
   // is computed from next-state values. Overflow is sticky until reset.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         wbin         <= '0;
         wgray        <= '0;
         full_out     <= 1'b0;
         level_out    <= '0;
         overflow_out <= 1'b0;
      end else begin
         wbin      <= wbin_next;
         wgray     <= wgray_next;
         full_out  <= full_next;
         level_out <= level_next;
         if (write_in && full_out) begin
            overflow_out <= 1'b1;
         end
      end
   end

`ifdef FIFO_ALMOST_FULL_EN
   localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(AF_THRESHOLD);

   // Almost-full uses the same difference as level_out, so the two move together.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         almost_full_out <= 1'b0;
      end else begin
         almost_full_out <= (level_next >= AF_LEVEL);
      end
   end
`endif

   assign write_ptr_out      = wbin;
   assign write_ptr_gray_out = wgray;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_fifo_wptr_full
// Self-checking bench for fifo_wptr_full (DEPTH=16, PTR_WIDTH=5,
// SYNC_STAGES=2). A behavioural model in the bench works in terms of write
// count minus synchronised read count. It pushes the expected outputs for
// every driven cycle onto a scoreboard queue. That entry is popped and
// compared after the clock edge. Honours FIFO_ALMOST_FULL_EN.
// ---------------------------------------------------------------------------
module tb_fifo_wptr_full;

   logic       w_clk;
   logic       w_rst_n;
   logic       write_in;
   logic [4:0] read_ptr_gray_in;
   logic [4:0] write_ptr_out;
   logic [4:0] write_ptr_gray_out;
   logic       full_out;
   logic [4:0] level_out;
   logic       overflow_out;
`ifdef FIFO_ALMOST_FULL_EN
   logic       almost_full_out;
`endif

   fifo_wptr_full #(
      .DEPTH(16), .PTR_WIDTH(5), .SYNC_STAGES(2), .AF_THRESHOLD(12)
   ) dut (
      .w_clk              (w_clk),
      .w_rst_n            (w_rst_n),
      .write_in           (write_in),
      .read_ptr_gray_in   (read_ptr_gray_in),
      .write_ptr_out      (write_ptr_out),
      .write_ptr_gray_out (write_ptr_gray_out),
      .full_out           (full_out),
      .level_out          (level_out),
      .overflow_out       (overflow_out)
`ifdef FIFO_ALMOST_FULL_EN
      ,
      .almost_full_out    (almost_full_out)
`endif
   );

   // 10-unit write clock.
   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   typedef struct {
      logic [4:0] wptr;
      logic [4:0] wgray;
      logic [4:0] level;
      logic       full;
      logic       ovf;
      logic       af;
   } exp_t;

   exp_t sb[$];

   int testsRun = 0;
   int testsFailed = 0;

   // Model state: write count, two-deep model of the read-pointer synchroniser.
   int m_wbin, m_s0, m_rq, m_level;
   logic m_full, m_ovf;

   function automatic logic [4:0] bin2gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   // Single comparison point: counts every check, reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic resetModel();
      m_wbin = 0; m_s0 = 0; m_rq = 0; m_level = 0;
      m_full = 1'b0; m_ovf = 1'b0;
      sb.delete();
   endtask

   // Asserts reset at the current time, checks outputs clear without a clock,
   // then releases it at the next falling edge.
   task automatic resetDut();
      w_rst_n = 1'b0;
      write_in = 1'b0;
      read_ptr_gray_in = 5'd0;
      #1;
      checkOutput("rst_wptr", 32'(write_ptr_out), 32'd0);
      checkOutput("rst_wgray", 32'(write_ptr_gray_out), 32'd0);
      checkOutput("rst_full", 32'(full_out), 32'd0);
      checkOutput("rst_level", 32'(level_out), 32'd0);
      checkOutput("rst_ovf", 32'(overflow_out), 32'd0);
`ifdef FIFO_ALMOST_FULL_EN
      checkOutput("rst_af", 32'(almost_full_out), 32'd0);
`endif
      resetModel();
      @(negedge w_clk);
      w_rst_n = 1'b1;
   endtask

   // Drives one cycle of stimulus, pushes the model's expectation, then pops
   // and compares it after the active edge.
   task automatic applyStimulus(input logic wr, input int rptr);
      exp_t e;
      exp_t got;
      @(negedge w_clk);
      write_in = wr;
      read_ptr_gray_in = bin2gray(5'(rptr));
      if (wr && m_full) m_ovf = 1'b1;
      if (wr && !m_full) m_wbin = (m_wbin + 1) % 32;
      m_level = (m_wbin - m_rq + 32) % 32;
      m_full = (m_level == 16);
      m_rq = m_s0;
      m_s0 = rptr % 32;
      e.wptr  = 5'(m_wbin);
      e.wgray = bin2gray(5'(m_wbin));
      e.level = 5'(m_level);
      e.full  = m_full;
      e.ovf   = m_ovf;
      e.af    = (m_level >= 12);
      sb.push_back(e);
      @(posedge w_clk);
      #1;
      got = sb.pop_front();
      checkOutput("wptr", 32'(write_ptr_out), 32'(got.wptr));
      checkOutput("wgray", 32'(write_ptr_gray_out), 32'(got.wgray));
      checkOutput("full", 32'(full_out), 32'(got.full));
      checkOutput("level", 32'(level_out), 32'(got.level));
      checkOutput("ovf", 32'(overflow_out), 32'(got.ovf));
`ifdef FIFO_ALMOST_FULL_EN
      checkOutput("af", 32'(almost_full_out), 32'(got.af));
`endif
   endtask

   initial begin
      logic [4:0] walkGray [4];
      int walkIdx;
      walkGray[0] = 5'b10001;
      walkGray[1] = 5'b10000;
      walkGray[2] = 5'b00000;
      walkGray[3] = 5'b00001;

      w_rst_n = 1'b0;
      write_in = 1'b0;
      read_ptr_gray_in = 5'd0;
      #12;
      resetDut();

      // Fill with 16 back-to-back writes, read pointer held at 0.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 0);
         checkOutput("fill_wptr", 32'(write_ptr_out), 32'(i + 1));
      end
      checkOutput("fill_full", 32'(full_out), 32'd1);
      checkOutput("fill_level", 32'(level_out), 32'd16);
      checkOutput("fill_gray", 32'(write_ptr_gray_out), 32'b11000);

      // Writes while full are dropped and set the sticky overflow flag.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0);
      applyStimulus(1'b0, 0);
      checkOutput("ovf_wptr", 32'(write_ptr_out), 32'd16);
      checkOutput("ovf_flag", 32'(overflow_out), 32'd1);
      checkOutput("ovf_level", 32'(level_out), 32'd16);

      // One read: full clears exactly three edges later.
      applyStimulus(1'b0, 1);
      checkOutput("rd_full_e1", 32'(full_out), 32'd1);
      applyStimulus(1'b0, 1);
      checkOutput("rd_full_e2", 32'(full_out), 32'd1);
      applyStimulus(1'b0, 1);
      checkOutput("rd_full_e3", 32'(full_out), 32'd0);
      checkOutput("rd_level", 32'(level_out), 32'd15);
      applyStimulus(1'b1, 1);
      checkOutput("rd_accept", 32'(write_ptr_out), 32'd17);

      // Asynchronous reset mid-burst at wbin=7, then the first write gives 1.
      @(negedge w_clk);
      resetDut();
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 0);
      checkOutput("mid_wptr7", 32'(write_ptr_out), 32'd7);
      #2;
      resetDut();
      applyStimulus(1'b1, 0);
      checkOutput("post_rst_wptr", 32'(write_ptr_out), 32'd1);

      // Pointer walk with reads tracking, across the 31 -> 0 wrap.
      @(negedge w_clk);
      resetDut();
      walkIdx = 0;
      for (int n = 1; n <= 33; n++) begin
         applyStimulus(1'b1, n - 1);
         if (n >= 30) begin
            checkOutput("walk_gray", 32'(write_ptr_gray_out), 32'(walkGray[walkIdx]));
            walkIdx++;
         end
         checkOutput("walk_lvl_le1", 32'(level_out <= 5'd1), 32'd1);
         for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, n % 32);
            checkOutput("walk_nofull", 32'(full_out), 32'd0);
         end
      end

`ifdef FIFO_ALMOST_FULL_EN
      // Almost-full threshold at level 12.
      @(negedge w_clk);
      resetDut();
      for (int i = 0; i < 11; i++) applyStimulus(1'b1, 0);
      checkOutput("af_at11", 32'(almost_full_out), 32'd0);
      applyStimulus(1'b1, 0);
      checkOutput("af_at12", 32'(almost_full_out), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
